sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_pkg.sv | 22 ++
 rtl/sram_port_arbiter_rr_arb2.sv | 26 ++
 rtl/sram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
//   state_e : arbiter FSM state encoding
//   gnt_e   : which requester owns the current/last access
//   ADDR_W, DATA_W : SRAM address and data widths
package sram_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } gnt_e;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin selector, purely combinational.
//   req   : request vector, bit 0 = fetch, bit 1 = load/store
//   last  : requester granted most recently
//   gnt   : selected requester (meaningful only when valid=1)
//   valid : at least one request is pending
module rr_arb2
    import sram_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_e       last,
    output gnt_e       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = GNT_INST;
        if (&req) begin
            // Contention: hand the port to whoever did not have it last.
            gnt = (last == GNT_INST) ? GNT_DATA : GNT_INST;
        end else if (req[1]) begin
            gnt = GNT_DATA;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported synchronous SRAM between a fetch port and a
// load/store port. Each access takes a fixed four-cycle IDLE/ISSUE/WAIT/RESP
// sequence: grant sampled in IDLE, SRAM strobed in ISSUE, read data captured
// in WAIT, one-cycle ack in RESP.
//   clk, reset                       : clock, async active-high reset
//   inst_req/addr -> inst_rdata/ack  : fetch port (read only)
//   data_req/we/addr/wdata -> data_rdata/ack : load/store port
//   sram_en/we/addr/wdata, sram_rdata: SRAM side, rdata valid one cycle after en
//   busy                             : high whenever the FSM is not in IDLE
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ack,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ack,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    gnt_e              last_grant_q;  // also identifies the in-flight owner
    logic              we_q;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;
    logic              sram_en_q, sram_we_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;

    gnt_e              arb_gnt;
    logic              arb_valid;
    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req   ({data_req, inst_req}),
        .last  (last_grant_q),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (arb_valid) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  state_d = RESP;
            RESP:  state_d = IDLE;
        endcase
    end

    assign grant     = (state_q == IDLE) && arb_valid;
    assign sel_we    = (arb_gnt == GNT_DATA) && data_we;
    assign sel_addr  = (arb_gnt == GNT_DATA) ? data_addr : inst_addr;
    assign sel_wdata = (arb_gnt == GNT_DATA) ? data_wdata : '0;

    // Stores leave the response register untouched.
    assign resp_d = we_q ? resp_q : sram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_INST;
            we_q         <= 1'b0;
            resp_q       <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            // The SRAM strobe registers double as the captured address/data:
            // loaded on the grant edge so they are live exactly for ISSUE,
            // and cleared on every other edge.
            sram_en_q    <= grant;
            sram_we_q    <= grant && sel_we;
            sram_addr_q  <= grant ? sel_addr : '0;
            sram_wdata_q <= grant ? sel_wdata : '0;
            if (grant) begin
                last_grant_q <= arb_gnt;
                we_q         <= sel_we;
            end
            if (state_q == WAIT) begin
                resp_q <= resp_d;
                if (last_grant_q == GNT_INST) begin
                    inst_rdata_q <= resp_d;
                end else begin
                    data_rdata_q <= resp_d;
                end
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign inst_ack   = (state_q == RESP) && (last_grant_q == GNT_INST);
    assign data_ack   = (state_q == RESP) && (last_grant_q == GNT_DATA);
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ack;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ack;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    int got;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ack   (inst_ack),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ack   (data_ack),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .busy       (busy)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Outputs sampled and inputs driven on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_we = 1'b0;
        data_addr = '0; data_wdata = '0; sram_rdata = '0;
        step(); step();

        // Reset state
        check1("rst_busy", busy, 1'b0);
        check1("rst_sram_en", sram_en, 1'b0);
        check1("rst_inst_ack", inst_ack, 1'b0);
        check1("rst_data_ack", data_ack, 1'b0);
        check32("rst_sram_addr", sram_addr, 32'h0);
        check32("rst_inst_rdata", inst_rdata, 32'h0);
        check32("rst_data_rdata", data_rdata, 32'h0);

        // Store, requested in the very first cycle after reset release
        reset = 1'b0; data_req = 1'b1; data_we = 1'b1;
        data_addr = 32'h0000_0100; data_wdata = 32'hdead_beef; sram_rdata = 32'h5555_5555;
        step(); // T+1
        check1("st_en", sram_en, 1'b1);
        check1("st_we", sram_we, 1'b1);
        check32("st_addr", sram_addr, 32'h0000_0100);
        check32("st_wdata", sram_wdata, 32'hdead_beef);
        check1("st_busy", busy, 1'b1);
        check1("st_no_early_ack", data_ack, 1'b0);
        step(); // T+2
        check1("st_en_off", sram_en, 1'b0);
        check1("st_we_off", sram_we, 1'b0);
        step(); // T+3
        check1("st_ack", data_ack, 1'b1);
        check1("st_no_inst_ack", inst_ack, 1'b0);
        check32("st_rdata_unchanged", data_rdata, 32'h0);
        data_req = 1'b0; data_we = 1'b0;
        step(); // T+4
        check1("st_ack_pulse", data_ack, 1'b0);
        check1("st_idle", busy, 1'b0);

        // Fetch; req dropped early must not abort
        inst_req = 1'b1; inst_addr = 32'h1c00_0000; sram_rdata = 32'h1111_1111;
        step(); // T+1
        check1("if_en", sram_en, 1'b1);
        check1("if_we", sram_we, 1'b0);
        check32("if_addr", sram_addr, 32'h1c00_0000);
        check32("if_wdata", sram_wdata, 32'h0);
        inst_req = 1'b0; sram_rdata = 32'h0280_0c0c;
        step(); // T+2
        check1("if_no_early_ack", inst_ack, 1'b0);
        check1("if_busy", busy, 1'b1);
        step(); // T+3
        sram_rdata = 32'h3333_3333;
        check1("if_ack", inst_ack, 1'b1);
        check32("if_rdata", inst_rdata, 32'h0280_0c0c);
        check1("if_no_data_ack", data_ack, 1'b0);
        check32("if_data_rdata_hold", data_rdata, 32'h0);
        step(); // T+4
        check1("if_ack_pulse", inst_ack, 1'b0);
        check1("if_idle", busy, 1'b0);
        check32("if_rdata_hold", inst_rdata, 32'h0280_0c0c);

        // Load with inputs changed after the grant edge
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0100;
        step(); // T+1
        data_addr = 32'h0000_0200; data_we = 1'b1; data_wdata = 32'hffff_ffff;
        sram_rdata = 32'hcafe_f00d;
        check32("late_addr", sram_addr, 32'h0000_0100);
        check1("late_we", sram_we, 1'b0);
        step(); // T+2
        check1("late_en_off", sram_en, 1'b0);
        check32("late_addr_off", sram_addr, 32'h0);
        step(); // T+3
        check1("late_ack", data_ack, 1'b1);
        check32("late_rdata", data_rdata, 32'hcafe_f00d);
        check32("late_inst_hold", inst_rdata, 32'h0280_0c0c);
        data_req = 1'b0; data_we = 1'b0; data_addr = '0;
        step(); // T+4

        // Simultaneous requests straight out of reset: DATA first
        reset = 1'b1;
        step();
        reset = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_0400;
        data_req = 1'b1; data_addr = 32'h0000_0300; sram_rdata = 32'ha5a5_a5a5;
        for (int k = 1; k <= 8; k++) begin
            step();
            check1("sim_both_acks", inst_ack & data_ack, 1'b0);
            check1("sim_data_ack", data_ack, k == 3);
            check1("sim_inst_ack", inst_ack, k == 7);
            if (k == 1) check32("sim_first_addr", sram_addr, 32'h0000_0300);
            if (k == 5) check32("sim_second_addr", sram_addr, 32'h0000_0400);
            if (k == 3) begin
                check32("sim_data_rdata", data_rdata, 32'ha5a5_a5a5);
                data_req = 1'b0;
            end
            if (k == 7) begin
                check32("sim_inst_rdata", inst_rdata, 32'ha5a5_a5a5);
                inst_req = 1'b0;
            end
            if (k == 8) check1("sim_idle", busy, 1'b0);
        end

        // Sustained contention: strict alternation starting with DATA
        inst_req = 1'b1; data_req = 1'b1; got = 0;
        for (int c = 0; c < 48 && got < 8; c++) begin
            step();
            inst_req = 1'b1; data_req = 1'b1;
            check1("cont_both_acks", inst_ack & data_ack, 1'b0);
            if (inst_ack || data_ack) begin
                check1("cont_order", data_ack, (got % 2) == 0);
                got++;
                if (data_ack) data_req = 1'b0;
                else inst_req = 1'b0;
            end
        end
        check32("cont_grants", got, 32'd8);
        inst_req = 1'b0; data_req = 1'b0;
        step(); step();

        // Reset during WAIT abandons the access
        inst_req = 1'b1; inst_addr = 32'h0000_0500;
        step(); // T+1
        step(); // T+2 (WAIT)
        reset = 1'b1;
        #1;
        check1("mid_busy", busy, 1'b0);
        check1("mid_sram_en", sram_en, 1'b0);
        check32("mid_sram_addr", sram_addr, 32'h0);
        check1("mid_inst_ack", inst_ack, 1'b0);
        check1("mid_data_ack", data_ack, 1'b0);
        check32("mid_inst_rdata", inst_rdata, 32'h0);
        check32("mid_data_rdata", data_rdata, 32'h0);
        step();
        check1("mid_held_ack", inst_ack, 1'b0);
        check1("mid_held_en", sram_en, 1'b0);
        reset = 1'b0; inst_addr = 32'h0000_0600; sram_rdata = 32'h1234_5678;
        step(); // T+1
        check1("re_en", sram_en, 1'b1);
        check32("re_addr", sram_addr, 32'h0000_0600);
        inst_req = 1'b0;
        step(); // T+2
        check1("re_no_early_ack", inst_ack, 1'b0);
        step(); // T+3
        check1("re_ack", inst_ack, 1'b1);
        check32("re_rdata", inst_rdata, 32'h1234_5678);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
